iter_shifter: RTL
=================

ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (>=2).
REQ-002 SHALL have parameter STEP, default 1, max single-bit shifts per cycle (1..WIDTH).
REQ-003 SHALL have localparam CNT_W = $clog2(WIDTH)+1, count width.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 fn  input  3  operation: 0 SHL, 1 SHR, 2 ROL, 3 ROR, 4 ASR, 5 RCL, 6 RCR, 7 PASS.
REQ-008 shiftCount  input  CNT_W  number of single-bit shifts.
REQ-009 cin  input  1  carry-in for RCL/RCR and count-0 carry.
REQ-010 in  input  WIDTH  operand.
REQ-011 busy  output  1  high in SHIFT and DONE.
REQ-012 done  output  1  one-cycle pulse, result valid.
REQ-013 out  output  WIDTH  result, registered, held until next accepted start.
REQ-014 shiftC  output  1  carry flag, registered.
REQ-015 shiftZ  output  1  high when out == 0.
REQ-016 shiftN  output  1  equals out[WIDTH-1].

Function
REQ-017 FSM states: IDLE, SHIFT, DONE; reset state IDLE.
REQ-018 IDLE + start: latch fn, shiftCount, in, cin (cin into carry register); go SHIFT if count>0, else DONE.
REQ-019 start outside IDLE SHALL be ignored, with no effect on latched operands or outputs.
REQ-020 SHIFT: each cycle apply min(STEP, remaining) single-bit shifts, decrement remaining accordingly; go DONE when remaining reaches 0.
REQ-021 Latency: done asserts exactly ceil(count/STEP)+1 cycles after start-accepting edge; count 0 -> 1 cycle.
REQ-022 DONE lasts one cycle, done=1, then IDLE; start in that cycle ignored.
REQ-023 SHL: shift left, LSB fill 0, carry = bit shifted out of MSB.
REQ-024 SHR: shift right, MSB fill 0, carry = bit shifted out of LSB.
REQ-025 ASR: shift right, MSB fill = old MSB, carry = bit out of LSB.
REQ-026 ROL/ROR: WIDTH-bit rotate; carry = bit that crossed the boundary on the last step.
REQ-027 RCL/RCR: (WIDTH+1)-bit rotate through carry register.
REQ-028 PASS: out = in, carry = 0, latency per count as other modes.
REQ-029 Counts >= WIDTH SHALL be honoured bitwise: SHL/SHR by >WIDTH give out 0, carry 0; by exactly WIDTH carry = in[0] (SHL) / in[WIDTH-1] (SHR); rotates wrap modulo naturally.
REQ-030 Count 0: out = in, shiftC = cin, all modes.
REQ-031 out/shiftC SHALL update only during SHIFT/count-0 load; shiftZ/shiftN combinational from out.

Reset
REQ-032 rst high SHALL immediately force IDLE, busy=0, done=0, out=0, shiftC=0, remaining=0 (hence shiftZ=1, shiftN=0).
REQ-033 rst mid-SHIFT SHALL abort the operation with no done pulse; first start after release SHALL work normally.

Verification (WIDTH=8, STEP=1 unless stated)
REQ-034 SHL in=0x81 count=1 -> out 0x02, C=1, Z=0, done 2 cycles after start.
REQ-035 ROR in=0x01 count=3 -> out 0x20, C=0; ROL in=0x80 count=1 -> out 0x01, C=1.
REQ-036 ASR in=0x80 count=9 -> out 0xFF, C=1, N=1; SHL in=0x01 count=8 -> out 0x00, C=1, Z=1.
REQ-037 RCL in=0x80 cin=0 count=1 -> out 0x00, C=1, Z=1; RCR in=0x00 cin=1 count=1 -> out 0x80, C=0.
REQ-038 count=0, in=0x5A, cin=1 -> done next cycle, out 0x5A, C=1; STEP=4 SHR in=0xF0 count=6 -> out 0x03, C=1, done 3 cycles after start.
REQ-039 start pulsed during SHIFT ignored; rst asserted mid-SHIFT -> out 0, no done; subsequent SHL 0x01 count 2 -> 0x04.

Source files
------------

// File: rtl/iter_shifter_if.sv
// rtl/iter_shifter_if.sv - request/result bundle for the iterative shifter
interface iter_shifter_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             start;
    logic [2:0]       fn;
    logic [CNT_W-1:0] shiftCount;
    logic             cin;
    logic [WIDTH-1:0] in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             shiftC;
    logic             shiftZ;
    logic             shiftN;

    modport master (
        output start, fn, shiftCount, cin, in,
        input  busy, done, out, shiftC, shiftZ, shiftN
    );

    modport slave (
        input  start, fn, shiftCount, cin, in,
        output busy, done, out, shiftC, shiftZ, shiftN
    );
endinterface

// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle shifter/rotator, up to STEP single-bit shifts per cycle
module iter_shifter #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input logic          clk,
    input logic          rst,
    iter_shifter_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, stateNext;
    logic [2:0]       fnReg;
    logic [CNT_W-1:0] remaining, stepNow;
    logic [WIDTH-1:0] work, workNext, outReg;
    logic             carry, carryNext, cReg;

    // One single-bit step; result is {carry, data}.
    function automatic logic [WIDTH:0] shiftOnce(input logic [2:0] f,
                                                  input logic [WIDTH-1:0] d,
                                                  input logic c);
        case (f)
            3'd0:    return {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
            3'd1:    return {d[0], 1'b0, d[WIDTH-1:1]};
            3'd2:    return {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
            3'd3:    return {d[0], d[0], d[WIDTH-1:1]};
            3'd4:    return {d[0], d[WIDTH-1], d[WIDTH-1:1]};
            3'd5:    return {d[WIDTH-1], d[WIDTH-2:0], c};
            3'd6:    return {d[0], c, d[WIDTH-1:1]};
            default: return {1'b0, d};
        endcase
    endfunction

    always_comb begin
        stepNow   = (remaining < CNT_W'(STEP)) ? remaining : CNT_W'(STEP);
        workNext  = work;
        carryNext = carry;
        for (int k = 0; k < STEP; k++) begin
            if (CNT_W'(k) < stepNow)
                {carryNext, workNext} = shiftOnce(fnReg, workNext, carryNext);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.start) stateNext = (bus.shiftCount == '0) ? DONE : SHIFT;
            SHIFT:   if (remaining == stepNow) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
    end

    // Visible result only moves while shifting or on a zero-count load, so a
    // start with count>0 leaves the previous result on out until the first step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fnReg     <= '0;
            remaining <= '0;
            work      <= '0;
            carry     <= 1'b0;
            outReg    <= '0;
            cReg      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        fnReg     <= bus.fn;
                        remaining <= bus.shiftCount;
                        work      <= bus.in;
                        carry     <= bus.cin;
                        if (bus.shiftCount == '0) begin
                            outReg <= bus.in;
                            cReg   <= bus.cin;
                        end
                    end
                end
                SHIFT: begin
                    work      <= workNext;
                    carry     <= carryNext;
                    remaining <= remaining - stepNow;
                    outReg    <= workNext;
                    cReg      <= carryNext;
                end
                default: ;
            endcase
        end
    end

    assign bus.out    = outReg;
    assign bus.shiftC = cReg;
    assign bus.shiftZ = (outReg == '0);
    assign bus.shiftN = outReg[WIDTH-1];
endmodule
